// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave to register-bus bridge. A frame is R/W bit, address, then data, MSB first.
// Each chip select addresses its own register bank; all SPI pins are oversampled by master_clk.
module spi_reg_bridge #(
   parameter int NUM_CS = 2,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16,
   localparam int BANK_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              master_clk,
   input  logic              reset_n,
   input  logic              spi_sclk,
   input  logic              spi_simo,
   input  logic [NUM_CS-1:0] spi_cs_n,
   output logic              spi_somi,
   output logic              spi_somi_oe,
   output logic              wr_stb,
   output logic              rd_stb,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic [BANK_W-1:0] bank,
   input  logic [DATA_W-1:0] rd_data,
   output logic              err_multi_cs,
   output logic [7:0]        frame_cnt,
   output logic [3:0]        dbg
);

   localparam int CMD_BITS = ADDR_W + 1;
   localparam int MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
   localparam int CNT_W    = $clog2(MAX_BITS);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StCmd, StData, StHold} state_e;

   state_e              state_q, state_d;
   logic                sclk_s1, sclk_s2, sclk_s3;
   logic                simo_s1, simo_s2;
   logic [NUM_CS-1:0]   cs_s1, cs_s2;
   logic                sclk_rise, sclk_fall;
   logic                any_low, multi_low, active_high;
   logic [BANK_W-1:0]   low_idx;
   logic                start, cmd_done, data_done;
   logic [1:0]          settle_q;
   logic                settled;
   logic                armed_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [ADDR_W-1:0]   cmd_sr_q;
   logic [CMD_BITS-1:0] cmd_full;
   logic [DATA_W-2:0]   data_sr_q;
   logic [DATA_W-1:0]   data_full;
   logic                rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BANK_W-1:0]   bank_q;
   logic                wr_stb_q, rd_stb_q;
   logic [1:0]          rd_dly_q;
   logic [DATA_W-1:0]   tx_sr_q;
   logic                somi_q, oe_q;
   logic                err_q;
   logic [7:0]          frame_cnt_q;
   logic                cs1_dbg;

   // Two-flop synchronisers plus one history flop on SCLK for edge detection.
   always_ff @(posedge master_clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         simo_s1 <= 1'b0;
         simo_s2 <= 1'b0;
         cs_s1   <= '1;
         cs_s2   <= '1;
      end else begin
         sclk_s1 <= spi_sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         simo_s1 <= spi_simo;
         simo_s2 <= simo_s1;
         cs_s1   <= spi_cs_n;
         cs_s2   <= cs_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign sclk_fall = ~sclk_s2 & sclk_s3;

   always_comb begin
      any_low   = 1'b0;
      multi_low = 1'b0;
      low_idx   = '0;
      for (int i = 0; i < NUM_CS; i++) begin
         if (!cs_s2[i]) begin
            multi_low = multi_low | any_low;
            any_low   = 1'b1;
            low_idx   = BANK_W'(i);
         end
      end
   end

   assign active_high = cs_s2[bank_q];
   assign settled     = &settle_q;
   assign cmd_full    = {cmd_sr_q, simo_s2};
   assign data_full   = {data_sr_q, simo_s2};

   always_comb begin
      state_d = state_q;
      if (multi_low) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: if (armed_q && any_low) state_d = StCmd;
            StCmd: begin
               if (active_high) state_d = StIdle;
               else if (sclk_rise && bit_cnt_q == CMD_LAST) state_d = StData;
            end
            StData: begin
               if (active_high) state_d = StIdle;
               else if (sclk_rise && bit_cnt_q == DATA_LAST) state_d = StHold;
            end
            StHold: if (active_high) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
      start     = (state_q == StIdle) && (state_d == StCmd);
      cmd_done  = (state_q == StCmd)  && (state_d == StData);
      data_done = (state_q == StData) && (state_d == StHold);
   end

   always_ff @(posedge master_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         settle_q    <= '0;
         armed_q     <= 1'b0;
         bit_cnt_q   <= '0;
         cmd_sr_q    <= '0;
         data_sr_q   <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         bank_q      <= '0;
         wr_stb_q    <= 1'b0;
         rd_stb_q    <= 1'b0;
         rd_dly_q    <= '0;
         tx_sr_q     <= '0;
         somi_q      <= 1'b0;
         oe_q        <= 1'b0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_stb_q <= 1'b0;
         rd_stb_q <= 1'b0;
         rd_dly_q <= {rd_dly_q[0], rd_stb_q};

         // Synchronisers hold idle levels right after reset; ignore them until they reflect pins.
         if (!settled) settle_q <= settle_q + 2'd1;

         if (multi_low) begin
            err_q   <= 1'b1;
            armed_q <= 1'b0;
         end else if (start) begin
            armed_q <= 1'b0;
         end else if (state_q == StIdle && settled && !any_low) begin
            armed_q <= 1'b1;
         end

         if (start) begin
            bank_q    <= low_idx;
            bit_cnt_q <= '0;
         end

         if (sclk_rise && state_q == StCmd) begin
            cmd_sr_q  <= cmd_full[ADDR_W-1:0];
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         end
         if (sclk_rise && state_q == StData) begin
            data_sr_q <= data_full[DATA_W-2:0];
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         end

         if (cmd_done) begin
            addr_q    <= cmd_full[ADDR_W-1:0];
            rw_q      <= cmd_full[ADDR_W];
            rd_stb_q  <= cmd_full[ADDR_W];
            bit_cnt_q <= '0;
         end

         if (data_done) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            if (!rw_q) begin
               wdata_q  <= data_full;
               wr_stb_q <= 1'b1;
            end
         end

         // Read data is captured two cycles after rd_stb, ahead of the first falling SCLK.
         if (rd_dly_q[1] && state_q == StData) tx_sr_q <= rd_data;

         if (sclk_fall && state_q == StData && rw_q) begin
            somi_q  <= tx_sr_q[DATA_W-1];
            tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
            oe_q    <= 1'b1;
         end

         if (state_d == StIdle) begin
            somi_q   <= 1'b0;
            oe_q     <= 1'b0;
            rd_dly_q <= '0;
         end
      end
   end

   if (NUM_CS > 1) begin : g_dbg_cs1
      assign cs1_dbg = cs_s2[1];
   end else begin : g_dbg_tie
      assign cs1_dbg = 1'b1;
   end

   // A strobe already registered is dropped if a second chip select appears that cycle.
   assign wr_stb       = wr_stb_q & ~multi_low;
   assign rd_stb       = rd_stb_q & ~multi_low;
   assign addr         = addr_q;
   assign wdata        = wdata_q;
   assign bank         = bank_q;
   assign spi_somi     = somi_q & oe_q;
   assign spi_somi_oe  = oe_q;
   assign err_multi_cs = err_q;
   assign frame_cnt    = frame_cnt_q;
   assign dbg          = {sclk_s2, simo_s2, cs1_dbg, cs_s2[0]};

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: an SPI host model drives frames, expected strobes are
// queued per frame and popped by a monitor when the bridge strobes.
module tb_spi_reg_bridge;

   localparam int H = 4;  // SCLK half-period in master_clk cycles

   logic        master_clk = 1'b0;
   logic        reset_n    = 1'b0;
   logic        spi_sclk   = 1'b0;
   logic        spi_simo   = 1'b0;
   logic [1:0]  spi_cs_n   = 2'b11;
   logic [15:0] rd_data    = 16'hA5C3;
   logic        spi_somi, spi_somi_oe, wr_stb, rd_stb, err_multi_cs;
   logic [6:0]  addr;
   logic [15:0] wdata;
   logic [0:0]  bank;
   logic [7:0]  frame_cnt;
   logic [3:0]  dbg;

   typedef struct packed {
      logic        is_rd;
      logic [6:0]  addr;
      logic [15:0] data;
      logic        bank;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks  = 0;
   int          fails   = 0;
   int          strobes = 0;
   int          oe_bad  = 0;
   int          s0;
   logic [15:0] rx_word = '0;
   logic [7:0]  fc_exp  = '0;

   always #5 master_clk = ~master_clk;

   spi_reg_bridge dut (
      .master_clk   (master_clk),
      .reset_n      (reset_n),
      .spi_sclk     (spi_sclk),
      .spi_simo     (spi_simo),
      .spi_cs_n     (spi_cs_n),
      .spi_somi     (spi_somi),
      .spi_somi_oe  (spi_somi_oe),
      .wr_stb       (wr_stb),
      .rd_stb       (rd_stb),
      .addr         (addr),
      .wdata        (wdata),
      .bank         (bank),
      .rd_data      (rd_data),
      .err_multi_cs (err_multi_cs),
      .frame_cnt    (frame_cnt),
      .dbg          (dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge master_clk) begin
      if (wr_stb || rd_stb) begin
         strobes++;
         check("one_strobe", 32'(wr_stb & rd_stb), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_strobe", 32'(sb.size()), 32'd1);
         end else begin
            mon_e = sb.pop_front();
            check("strobe_kind", 32'(rd_stb), 32'(mon_e.is_rd));
            check("addr", 32'(addr), 32'(mon_e.addr));
            check("bank", 32'(bank), 32'(mon_e.bank));
            if (!mon_e.is_rd) check("wdata", 32'(wdata), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic shift_bits(input logic [23:0] w, input int first, input int n,
                             input logic is_rd);
      for (int i = first; i < first + n; i++) begin
         spi_simo = w[23-i];
         repeat (H) @(posedge master_clk);
         spi_sclk = 1'b1;
         if (i >= 8) rx_word[23-i] = spi_somi;
         if (spi_somi_oe !== (is_rd && i >= 8)) oe_bad++;
         if (!spi_somi_oe && spi_somi !== 1'b0) oe_bad++;
         repeat (H) @(posedge master_clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic frame(input int cs, input logic is_rd, input logic [6:0] a,
                        input logic [15:0] d, input int extra_pulses);
      exp_t e;
      e.is_rd = is_rd;
      e.addr  = a;
      e.data  = d;
      e.bank  = 1'(cs);
      sb.push_back(e);
      fc_exp++;
      oe_bad = 0;
      spi_cs_n[cs] = 1'b0;
      shift_bits({is_rd, a, d}, 0, 24, is_rd);
      for (int k = 0; k < extra_pulses; k++) begin
         repeat (H) @(posedge master_clk);
         spi_sclk = 1'b1;
         repeat (H) @(posedge master_clk);
         spi_sclk = 1'b0;
      end
      repeat (H) @(posedge master_clk);
      spi_cs_n = 2'b11;
      repeat (2 * H) @(posedge master_clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_wr_stb"}, 32'(wr_stb), 32'd0);
      check({tag, "_rd_stb"}, 32'(rd_stb), 32'd0);
      check({tag, "_somi"}, 32'(spi_somi), 32'd0);
      check({tag, "_somi_oe"}, 32'(spi_somi_oe), 32'd0);
      check({tag, "_err"}, 32'(err_multi_cs), 32'd0);
      check({tag, "_addr"}, 32'(addr), 32'd0);
      check({tag, "_wdata"}, 32'(wdata), 32'd0);
      check({tag, "_bank"}, 32'(bank), 32'd0);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge master_clk);
      #1;
      check_reset("por");
      check("por_dbg", 32'(dbg), 32'h3);
      reset_n = 1'b1;
      repeat (2 * H) @(posedge master_clk);

      // Write on cs0
      frame(0, 1'b0, 7'h15, 16'hBEEF, 0);
      check("wr_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      check("wr_sb_empty", 32'(sb.size()), 32'd0);
      check("wr_oe", 32'(oe_bad), 32'd0);

      // Read on cs1
      frame(1, 1'b1, 7'h03, 16'h0000, 0);
      check("rd_somi_word", 32'(rx_word), 32'hA5C3);
      check("rd_oe", 32'(oe_bad), 32'd0);
      check("rd_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      check("rd_sb_empty", 32'(sb.size()), 32'd0);
      check("rd_oe_after", 32'(spi_somi_oe), 32'd0);
      check("rd_somi_after", 32'(spi_somi), 32'd0);

      // Abort after 10 rising edges, then a normal write
      s0 = strobes;
      spi_cs_n[0] = 1'b0;
      shift_bits({1'b0, 7'h2A, 16'h5555}, 0, 10, 1'b0);
      spi_cs_n = 2'b11;
      repeat (2 * H) @(posedge master_clk);
      check("abort_strobes", 32'(strobes), 32'(s0));
      check("abort_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      frame(0, 1'b0, 7'h2A, 16'h1234, 0);
      check("post_abort_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      check("post_abort_sb_empty", 32'(sb.size()), 32'd0);

      // Second chip select joins mid-data
      s0 = strobes;
      spi_cs_n[0] = 1'b0;
      shift_bits({1'b0, 7'h44, 16'h9999}, 0, 12, 1'b0);
      spi_cs_n[1] = 1'b0;
      shift_bits({1'b0, 7'h44, 16'h9999}, 12, 12, 1'b0);
      check("multi_err_set", 32'(err_multi_cs), 32'd1);
      spi_cs_n = 2'b11;
      repeat (2 * H) @(posedge master_clk);
      check("multi_err_sticky", 32'(err_multi_cs), 32'd1);
      check("multi_strobes", 32'(strobes), 32'(s0));
      check("multi_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      frame(1, 1'b0, 7'h7F, 16'h0F0F, 0);
      check("post_multi_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      check("post_multi_err", 32'(err_multi_cs), 32'd1);
      @(negedge master_clk);
      reset_n = 1'b0;
      fc_exp  = '0;
      #1;
      check_reset("multi_rst");
      repeat (3) @(posedge master_clk);
      reset_n = 1'b1;
      repeat (2 * H) @(posedge master_clk);

      // Reset mid-data of a write; cs0 held low through and after reset
      s0 = strobes;
      spi_cs_n[0] = 1'b0;
      shift_bits({1'b0, 7'h66, 16'hCAFE}, 0, 12, 1'b0);
      @(negedge master_clk);
      reset_n = 1'b0;
      #1;
      check_reset("mid_rst");
      repeat (3) @(posedge master_clk);
      reset_n = 1'b1;
      shift_bits({1'b0, 7'h66, 16'hCAFE}, 12, 12, 1'b0);
      shift_bits({1'b0, 7'h67, 16'hD00D}, 0, 24, 1'b0);
      spi_cs_n = 2'b11;
      repeat (2 * H) @(posedge master_clk);
      check("mid_rst_strobes", 32'(strobes), 32'(s0));
      check("mid_rst_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      frame(0, 1'b0, 7'h11, 16'hC0DE, 0);
      check("post_rst_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

      // Back-to-back writes up to the frame counter wrap, last one with 30 extra edges in HOLD
      for (int n = 0; n < 254; n++) begin
         frame(n % 2, 1'b0, 7'($urandom), 16'($urandom), 0);
      end
      check("wrap_pre_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      s0 = strobes;
      frame(1, 1'b0, 7'h5A, 16'h8001, 15);
      check("wrap_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
      check("hold_strobes", 32'(strobes), 32'(s0 + 1));
      check("wrap_sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
